// File: rtl/cd_csr_arb_pkg.sv
// Shared constants and types for the CDBUS CSR-port arbiter.
package cd_csr_arb_pkg;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int WDOG_W = 16;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED0  = 2'd1,
    LOCKED1  = 2'd2
  } lock_state_e;

endpackage

// File: rtl/cd_rd_track.sv
// Read-return tracker: a RD_LATENCY-deep {valid, id} pipe that steers the
// slave's read-data strobe back to the master that issued the read.
module cd_rd_track
  import cd_csr_arb_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ld_vld,
  input  logic ld_id,
  output logic m0_vld,
  output logic m1_vld,
  output logic busy
);

  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [RD_LATENCY-1:0] id_q, id_d;

  always_comb begin
    vld_d    = vld_q;
    id_d     = id_q;
    vld_d[0] = ld_vld;
    id_d[0]  = ld_id;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      id_d[i]  = id_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      id_q  <= '0;
    end else begin
      vld_q <= vld_d;
      id_q  <= id_d;
    end
  end

  assign m0_vld = vld_q[RD_LATENCY-1] & (id_q[RD_LATENCY-1] == M0);
  assign m1_vld = vld_q[RD_LATENCY-1] & (id_q[RD_LATENCY-1] == M1);
  assign busy   = |vld_q;

endmodule

// File: rtl/cd_csr_arb.sv
// Two-master arbiter for the CDBUS CSR port: round-robin or fixed priority,
// with a per-master lock for multi-word sequences and a lock watchdog.
module cd_csr_arb
  import cd_csr_arb_pkg::*;
#(
  parameter int RD_LATENCY   = 1,
  parameter int FIXED_PRIO   = 0,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  input  logic        m0_lock,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  output logic        m0_readdatavalid,
  input  logic [3:0]  m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  input  logic        m1_lock,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic        m1_readdatavalid,
  output logic [3:0]  csr_address,
  output logic        csr_read,
  output logic        csr_write,
  output logic [31:0] csr_writedata,
  input  logic [31:0] csr_readdata,
  output logic        chip_select,
  output logic        lock_timeout
);

  localparam logic [WDOG_W-1:0] TO_VAL = WDOG_W'(LOCK_TIMEOUT);

  lock_state_e       state_q, state_d;
  logic              last_q, last_d;
  logic              ign0_q, ign0_d, ign1_q, ign1_d;
  logic [WDOG_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic              req0, req1, lk0, lk1, sel0, sel1, acc0, acc1, timeout;
  logic              trk_busy;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;
  // A master whose lock was broken by the watchdog is treated as unlocked
  // until it has visibly dropped its lock request.
  assign lk0  = m0_lock & ~ign0_q;
  assign lk1  = m1_lock & ~ign1_q;

  always_comb begin
    sel0 = 1'b0;
    sel1 = 1'b0;
    case (state_q)
      LOCKED0: sel0 = req0;
      LOCKED1: sel1 = req1;
      default: begin
        if (req0 && req1) begin
          if (FIXED_PRIO != 0 || last_q == M1) sel0 = 1'b1;
          else                                 sel1 = 1'b1;
        end else begin
          sel0 = req0;
          sel1 = req1;
        end
      end
    endcase
  end

  assign acc0 = req0 & sel0;
  assign acc1 = req1 & sel1;
  assign m0_waitrequest = req0 & ~sel0;
  assign m1_waitrequest = req1 & ~sel1;

  // Read+write together is a write; with no selection the mux rests on m0.
  assign csr_address   = sel1 ? m1_address   : m0_address;
  assign csr_writedata = sel1 ? m1_writedata : m0_writedata;
  assign csr_write     = (sel0 & m0_write) | (sel1 & m1_write);
  assign csr_read      = (sel0 & m0_read & ~m0_write) | (sel1 & m1_read & ~m1_write);

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    ign0_d  = ign0_q & m0_lock;
    ign1_d  = ign1_q & m1_lock;
    timeout = 1'b0;
    if (acc0)      last_d = M0;
    else if (acc1) last_d = M1;
    case (state_q)
      LOCKED0: begin
        cnt_d = acc0 ? '0 : cnt_inc;
        if (!lk0) begin
          state_d = UNLOCKED;
          cnt_d   = '0;
        end else if (LOCK_TIMEOUT != 0 && !acc0 && cnt_inc == TO_VAL) begin
          state_d = UNLOCKED;
          cnt_d   = '0;
          timeout = 1'b1;
          ign0_d  = 1'b1;
        end
      end
      LOCKED1: begin
        cnt_d = acc1 ? '0 : cnt_inc;
        if (!lk1) begin
          state_d = UNLOCKED;
          cnt_d   = '0;
        end else if (LOCK_TIMEOUT != 0 && !acc1 && cnt_inc == TO_VAL) begin
          state_d = UNLOCKED;
          cnt_d   = '0;
          timeout = 1'b1;
          ign1_d  = 1'b1;
        end
      end
      default: begin
        cnt_d = '0;
        if (acc0 && lk0)      state_d = LOCKED0;
        else if (acc1 && lk1) state_d = LOCKED1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= UNLOCKED;
      last_q  <= M1;
      cnt_q   <= '0;
      ign0_q  <= 1'b0;
      ign1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      ign0_q  <= ign0_d;
      ign1_q  <= ign1_d;
    end
  end

  assign lock_timeout = timeout;

  cd_rd_track #(.RD_LATENCY(RD_LATENCY)) u_rd_track (
    .clk    (clk),
    .rst_n  (reset_n),
    .ld_vld (csr_read),
    .ld_id  (sel1),
    .m0_vld (m0_readdatavalid),
    .m1_vld (m1_readdatavalid),
    .busy   (trk_busy)
  );

  assign m0_readdata = csr_readdata;
  assign m1_readdata = csr_readdata;
  assign chip_select = csr_read | csr_write | trk_busy;

endmodule
